// File: rtl/bash_f_ctrl.sv
// bash-f permutation: one-round datapath plus an iterative sequencer.
// The sequencer chains UNROLL rounds per clock over a 1536-bit state.
package bash_hash_params_pkg;
   localparam int SLEN = 64;
endpackage

module bash_f
   import bash_hash_params_pkg::*;
(
   input  logic [24*SLEN-1:0] s_i,
   input  logic [SLEN-1:0]    c_i,
   output logic [24*SLEN-1:0] s_o
);
   localparam int M1 [8] = '{8, 56, 8, 56, 8, 56, 8, 56};
   localparam int N1 [8] = '{53, 51, 37, 3, 21, 19, 5, 35};
   localparam int M2 [8] = '{14, 34, 46, 2, 14, 34, 46, 2};
   localparam int N2 [8] = '{1, 7, 49, 23, 33, 39, 17, 55};
   localparam int P [24] = '{15, 10, 9, 12, 11, 14, 13, 8,
                             17, 16, 19, 18, 21, 20, 23, 22,
                             6, 3, 0, 7, 2, 5, 4, 1};

   function automatic logic [SLEN-1:0] rotl(
      input logic [SLEN-1:0] x,
      input int              n
   );
      return (x << n) | (x >> (SLEN - n));
   endfunction

   logic [SLEN-1:0] w [24];

   // S-box layer: each column (i, i+8, i+16) goes through bash-s
   for (genvar i = 0; i < 8; i++) begin : g_col
      logic [SLEN-1:0] a, b, c, t0, t1, x0, x1, x2;
      assign a  = s_i[SLEN*i +: SLEN];
      assign b  = s_i[SLEN*(i+8) +: SLEN];
      assign c  = s_i[SLEN*(i+16) +: SLEN];
      assign t0 = rotl(a, M1[i]);
      assign x0 = a ^ b ^ c;
      assign t1 = b ^ rotl(x0, N1[i]);
      assign x1 = t0 ^ t1;
      assign x2 = c ^ rotl(c, M2[i]) ^ rotl(t1, N2[i]);
      assign w[i]    = x0 ^ (~x2 | x1);
      assign w[i+8]  = x1 ^ (x0 | x2);
      assign w[i+16] = x2 ^ (x0 & x1);
   end

   // Word permutation, then the round constant lands in word 23
   for (genvar k = 0; k < 24; k++) begin : g_out
      if (k == 23) begin : g_c
         assign s_o[SLEN*k +: SLEN] = w[P[k]] ^ c_i;
      end else begin : g_p
         assign s_o[SLEN*k +: SLEN] = w[P[k]];
      end
   end
endmodule

module bash_f_ctrl
   import bash_hash_params_pkg::*;
#(
   parameter int          ROUNDS = 24,
   parameter int          UNROLL = 1,
   parameter logic [63:0] C_INIT = 64'h3BF5080AC8BA94B1,
   parameter logic [63:0] C_POLY = 64'hDC2BE1997FE0D8AE
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [24*SLEN-1:0] state_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [24*SLEN-1:0] state_o,
   output logic              busy_o,
   output logic [4:0]        round_o
);
   if (UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
      $error("bash_f_ctrl: UNROLL must divide ROUNDS");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

   localparam logic [4:0] LAST = 5'(ROUNDS - UNROLL);
   localparam logic [4:0] STEP = 5'(UNROLL);

   function automatic logic [SLEN-1:0] lfsr(input logic [SLEN-1:0] c);
      return (c >> 1) ^ (c[0] ? C_POLY : '0);
   endfunction

   st_t                st_q, st_d;
   logic [24*SLEN-1:0] s_q, s_d, s_nxt;
   logic [SLEN-1:0]    c_q, c_d, c_nxt;
   logic [4:0]         rnd_q, rnd_d;

   for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
      logic [24*SLEN-1:0] s_in, s_out;
      logic [SLEN-1:0]    c;
      if (j == 0) begin : g_first
         assign s_in = s_q;
         assign c    = c_q;
      end else begin : g_next
         assign s_in = g_rnd[j-1].s_out;
         assign c    = lfsr(g_rnd[j-1].c);
      end
      bash_f u_f (
         .s_i (s_in),
         .c_i (c),
         .s_o (s_out)
      );
   end

   assign s_nxt   = g_rnd[UNROLL-1].s_out;
   assign c_nxt   = lfsr(g_rnd[UNROLL-1].c);
   assign state_o = s_q;
   assign round_o = rnd_q;

   // State, constant and round registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q  <= IDLE;
         s_q   <= '0;
         c_q   <= C_INIT;
         rnd_q <= '0;
      end else begin
         st_q  <= st_d;
         s_q   <= s_d;
         c_q   <= c_d;
         rnd_q <= rnd_d;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      st_d        = st_q;
      s_d         = s_q;
      c_d         = c_q;
      rnd_d       = rnd_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = 1'b0;
      unique case (st_q)
         IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               st_d  = RUN;
               s_d   = state_i;
               c_d   = C_INIT;
               rnd_d = '0;
            end
         end
         RUN: begin
            busy_o = 1'b1;
            s_d    = s_nxt;
            c_d    = c_nxt;
            if (rnd_q == LAST) begin
               st_d  = DONE;
               rnd_d = '0;
            end else begin
               rnd_d = rnd_q + STEP;
            end
         end
         DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end
endmodule
